// File: rtl/keypad_pkg.sv
// Shared key codes, store-target encodings, entry states and the keypad map
// used by the scanner and the entry controller.
package keypad_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_EQ  = 4'hE;

  localparam logic [1:0] REGI_NONE = 2'd0;
  localparam logic [1:0] REGI_A    = 2'd1;
  localparam logic [1:0] REGI_B    = 2'd2;
  localparam logic [1:0] REGI_OP   = 2'd3;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    DONE    = 2'd2
  } entry_state_t;

  typedef enum logic [1:0] {
    SCAN_IDLE    = 2'd0,
    SCAN_PRESS   = 2'd1,
    SCAN_RELEASE = 2'd2
  } scan_state_t;

  // Physical layout: row 3 carries equals, zero and two unused keys.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = KEY_ADD;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = KEY_SUB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = KEY_CLR;
      4'b11_00: code = KEY_EQ;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  function automatic logic is_operator(input logic [3:0] code);
    return (code == KEY_ADD) || (code == KEY_SUB);
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// Column scanner with row synchroniser, press/release debounce and key decode.
// Emits a single-cycle key_valid per debounced press.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [1:0] scan_state
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);

  logic [3:0]       row_s1, row_s2;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       cand_row;
  logic [DEB_W-1:0] deb_cnt;
  scan_state_t      state;

  logic       sample;
  logic [3:0] rows_low;
  logic       single_low;
  logic [1:0] row_idx;

  assign scan_state = state;
  assign sample     = (div_cnt == DIV_W'(SCAN_DIV - 1));

  always_comb begin
    rows_low   = ~row_s2;
    single_low = (rows_low != 4'd0) && ((rows_low & (rows_low - 4'd1)) == 4'd0);
    row_idx    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (rows_low[i]) row_idx = 2'(i);
    end
  end

  // Debounce decisions are taken only on the last cycle of a dwell, so the
  // synchroniser has settled on the rows of the currently driven column.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1    <= 4'hF;
      row_s2    <= 4'hF;
      div_cnt   <= '0;
      col_idx   <= 2'd0;
      col_n     <= 4'b1110;
      cand_row  <= 2'd0;
      deb_cnt   <= '0;
      state     <= SCAN_IDLE;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      row_s1    <= row_n;
      row_s2    <= row_s1;
      key_valid <= 1'b0;
      div_cnt   <= sample ? '0 : div_cnt + 1'b1;

      if (sample) begin
        case (state)
          SCAN_IDLE: begin
            if (single_low) begin
              cand_row <= row_idx;
              if (DEBOUNCE_CNT <= 1) begin
                key_valid <= 1'b1;
                key_code  <= key_map(row_idx, col_idx);
                deb_cnt   <= '0;
                state     <= SCAN_RELEASE;
              end else begin
                deb_cnt <= DEB_W'(1);
                state   <= SCAN_PRESS;
              end
            end else begin
              col_idx <= col_idx + 2'd1;
              col_n   <= {col_n[2:0], col_n[3]};
            end
          end

          SCAN_PRESS: begin
            if (single_low && (row_idx == cand_row)) begin
              if (deb_cnt == DEB_W'(DEBOUNCE_CNT - 1)) begin
                key_valid <= 1'b1;
                key_code  <= key_map(cand_row, col_idx);
                deb_cnt   <= '0;
                state     <= SCAN_RELEASE;
              end else begin
                deb_cnt <= deb_cnt + 1'b1;
              end
            end else if (single_low) begin
              cand_row <= row_idx;
              deb_cnt  <= DEB_W'(1);
            end else begin
              // No key or a ghosting pattern: drop back to idle on this column.
              deb_cnt <= '0;
              state   <= SCAN_IDLE;
            end
          end

          SCAN_RELEASE: begin
            if (rows_low == 4'd0) begin
              if (deb_cnt == DEB_W'(DEBOUNCE_CNT - 1)) begin
                deb_cnt <= '0;
                state   <= SCAN_IDLE;
                col_idx <= col_idx + 2'd1;
                col_n   <= {col_n[2:0], col_n[3]};
              end else begin
                deb_cnt <= deb_cnt + 1'b1;
              end
            end else begin
              deb_cnt <= '0;
            end
          end

          default: begin
            deb_cnt <= '0;
            state   <= SCAN_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Calculator front end: keypad scanner plus the operand/operator entry FSM
// that drives nr/regi, clr and exec into the operand-register stage.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8,
  parameter int MAX_DIGITS   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] nr,
  output logic [1:0] regi,
  output logic       clr,
  output logic       exec,
  output logic [1:0] phase
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic             key_valid;
  logic [3:0]       key_code;
  logic [1:0]       scan_state;
  entry_state_t     state;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  keypad_scan #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .scan_state(scan_state)
  );

  // phase is the registered entry state, which doubles as the FSM debug view.
  assign phase = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ENTER_A;
      cnt_a <= '0;
      cnt_b <= '0;
      nr    <= 4'h0;
      regi  <= REGI_NONE;
      clr   <= 1'b0;
      exec  <= 1'b0;
    end else begin
      regi <= REGI_NONE;
      clr  <= 1'b0;
      exec <= 1'b0;

      if (key_valid) begin
        if (key_code == KEY_CLR) begin
          // Clear keeps nr: the downstream stage ignores nr without a regi pulse.
          clr   <= 1'b1;
          cnt_a <= '0;
          cnt_b <= '0;
          state <= ENTER_A;
        end else begin
          case (state)
            ENTER_A: begin
              if (is_digit(key_code)) begin
                if (cnt_a < CNT_W'(MAX_DIGITS)) begin
                  nr    <= key_code;
                  regi  <= REGI_A;
                  cnt_a <= cnt_a + 1'b1;
                end
              end else if (is_operator(key_code)) begin
                nr    <= key_code;
                regi  <= REGI_OP;
                state <= ENTER_B;
              end
            end

            ENTER_B: begin
              if (is_digit(key_code)) begin
                if (cnt_b < CNT_W'(MAX_DIGITS)) begin
                  nr    <= key_code;
                  regi  <= REGI_B;
                  cnt_b <= cnt_b + 1'b1;
                end
              end else if (is_operator(key_code)) begin
                nr   <= key_code;
                regi <= REGI_OP;
              end else if (key_code == KEY_EQ) begin
                exec  <= 1'b1;
                state <= DONE;
              end
            end

            DONE: begin
              state <= DONE;
            end

            default: begin
              state <= ENTER_A;
            end
          endcase
        end
      end
    end
  end

  // The scanner state is kept visible on the instance for debug probing.
  logic scan_state_unused;
  assign scan_state_unused = ^scan_state;

endmodule
